// File: rtl/hififo_pkg.sv
// Shared constants and helpers for the hififo BRAM-backed FIFO blocks.
package hififo_pkg;
  localparam int BRAM_FIFO_QDEPTH = 4;
  localparam int BRAM_RD_LATENCY  = 2;
  localparam int QCBITS           = $clog2(BRAM_FIFO_QDEPTH + 1);

  function automatic int ptr_bits(input int abits);
    return abits + 1;
  endfunction
endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read latency.
module block_ram
  import hififo_pkg::*;
#(
  parameter int ABITS = 9,
  parameter int DBITS = 64
) (
  input  logic             clock,
  input  logic             w_en,
  input  logic [ABITS-1:0] w_addr,
  input  logic [DBITS-1:0] w_data,
  input  logic             r_en,
  input  logic [ABITS-1:0] r_addr,
  output logic [DBITS-1:0] r_data
);
  logic [DBITS-1:0] mem  [2**ABITS];
  logic [DBITS-1:0] pipe [BRAM_RD_LATENCY];

  // Array read lands in pipe[0]; the remaining stages model the output registers.
  always_ff @(posedge clock) begin
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) pipe[0] <= mem[r_addr];
    for (int i = 1; i < BRAM_RD_LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign r_data = pipe[BRAM_RD_LATENCY-1];
endmodule

// File: rtl/prefetch_queue.sv
// Small register FIFO holding words already read out of the RAM.
module prefetch_queue
  import hififo_pkg::*;
#(
  parameter int DBITS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DBITS-1:0]  push_data,
  input  logic              pop,
  output logic [DBITS-1:0]  head,
  output logic [QCBITS-1:0] count
);
  localparam int IBITS = $clog2(BRAM_FIFO_QDEPTH);

  logic [DBITS-1:0] slots [BRAM_FIFO_QDEPTH];
  logic [IBITS-1:0] wr_idx, rd_idx;

  always_ff @(posedge clock) begin
    if (push) slots[wr_idx] <= push_data;
  end

  // The controller never pushes when full nor pops when empty, so no guards here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + IBITS'(1);
      if (pop)  rd_idx <= rd_idx + IBITS'(1);
      count <= count + QCBITS'(push) - QCBITS'(pop);
    end
  end

  assign head = slots[rd_idx];
endmodule

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready stream FIFO over a block_ram, with a prefetch queue hiding read latency.
// Define BRAM_FIFO_COUNT_EN to add the registered occupancy output 'count'.
module bram_fifo_ctrl
  import hififo_pkg::*;
#(
  parameter int ABITS = 9,
  parameter int DBITS = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DBITS-1:0] w_data,
  input  logic             w_valid,
  output logic             w_ready,
  output logic [DBITS-1:0] r_data,
  output logic             r_valid,
  input  logic             r_ready
`ifdef BRAM_FIFO_COUNT_EN
  ,
  output logic [ABITS+1:0] count
`endif
);
  localparam int                PBITS     = ptr_bits(ABITS);
  localparam logic [PBITS-1:0]  RAM_WORDS = PBITS'(2**ABITS);
  localparam logic [QCBITS-1:0] QDEPTH    = QCBITS'(BRAM_FIFO_QDEPTH);

  logic [PBITS-1:0]  wptr, rptr, wptr_next, rptr_next;
  logic              v1, v2, accept, pop, issue;
  logic [QCBITS-1:0] q_count, in_flight;
  logic [DBITS-1:0]  ram_rdata;

  assign accept    = w_valid & w_ready;
  assign pop       = r_valid & r_ready;
  assign r_valid   = (q_count != '0);
  // Reserve queue space for every word still travelling through the RAM pipeline.
  assign in_flight = q_count + QCBITS'(v1) + QCBITS'(v2);
  assign issue     = (wptr != rptr) && (in_flight < QDEPTH);
  assign wptr_next = wptr + PBITS'(accept);
  assign rptr_next = rptr + PBITS'(issue);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      w_ready <= 1'b0;
    end else begin
      wptr    <= wptr_next;
      rptr    <= rptr_next;
      v1      <= issue;
      v2      <= v1;
      w_ready <= (wptr_next - rptr_next) != RAM_WORDS;
    end
  end

`ifdef BRAM_FIFO_COUNT_EN
  localparam int CBITS = ABITS + 2;

  logic [QCBITS-1:0] q_next;
  logic [CBITS-1:0]  count_next;

  // Built from next-state values so 'count' matches the state it is registered with.
  assign q_next     = q_count + QCBITS'(v2) - QCBITS'(pop);
  assign count_next = CBITS'(wptr_next - rptr_next) + CBITS'(issue) + CBITS'(v1)
                    + CBITS'(q_next);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end
`endif

  block_ram #(.ABITS(ABITS), .DBITS(DBITS)) u_ram (
    .clock  (clock),
    .w_en   (accept),
    .w_addr (wptr[ABITS-1:0]),
    .w_data (w_data),
    .r_en   (issue),
    .r_addr (rptr[ABITS-1:0]),
    .r_data (ram_rdata)
  );

  prefetch_queue #(.DBITS(DBITS)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (v2),
    .push_data (ram_rdata),
    .pop       (pop),
    .head      (r_data),
    .count     (q_count)
  );
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed testbench for bram_fifo_ctrl at ABITS=4 (16-word RAM, 20-word capacity).
module tb_bram_fifo_ctrl;
  localparam int ABITS = 4;
  localparam int DBITS = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [DBITS-1:0] w_data = '0;
  logic             w_valid = 1'b0;
  logic             w_ready;
  logic [DBITS-1:0] r_data;
  logic             r_valid;
  logic             r_ready = 1'b0;
`ifdef BRAM_FIFO_COUNT_EN
  logic [ABITS+1:0] count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bram_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clock   (clock),
    .reset   (reset),
    .w_data  (w_data),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .r_data  (r_data),
    .r_valid (r_valid),
    .r_ready (r_ready)
`ifdef BRAM_FIFO_COUNT_EN
    ,
    .count   (count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; w_valid = 1'b0; r_ready = 1'b0;
    repeat (2) step();
    n_checks++;
    if (r_valid !== 1'b0) $display("[TB] FAIL reset_r_valid: got %b expected 0", r_valid); else n_pass++;
    n_checks++;
    if (w_ready !== 1'b0) $display("[TB] FAIL reset_w_ready: got %b expected 0", w_ready); else n_pass++;
`ifdef BRAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 6'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else n_pass++;
`endif
    reset = 1'b0;
    step();
    n_checks++;
    if (w_ready !== 1'b1) $display("[TB] FAIL release_w_ready: got %b expected 1", w_ready); else n_pass++;
    n_checks++;
    if (r_valid !== 1'b0) $display("[TB] FAIL release_r_valid: got %b expected 0", r_valid); else n_pass++;
  endtask

  task automatic test_single_word();
    r_ready = 1'b0;
    w_data  = 16'hA5A5;
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    // After the accepting edge and the next two edges the word is still in flight.
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (r_valid !== 1'b0) $display("[TB] FAIL single_early_valid[%0d]: got %b expected 0", k, r_valid); else n_pass++;
      step();
    end
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== 16'hA5A5)
      $display("[TB] FAIL single_arrive: got valid=%b data=%h expected valid=1 data=a5a5", r_valid, r_data);
    else n_pass++;
    repeat (3) begin
      step();
      n_checks++;
      if (r_valid !== 1'b1 || r_data !== 16'hA5A5)
        $display("[TB] FAIL single_hold: got valid=%b data=%h expected valid=1 data=a5a5", r_valid, r_data);
      else n_pass++;
    end
`ifdef BRAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 6'd1) $display("[TB] FAIL single_count: got %0d expected 1", count); else n_pass++;
`endif
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    n_checks++;
    if (r_valid !== 1'b0) $display("[TB] FAIL single_empty: got %b expected 0", r_valid); else n_pass++;
  endtask

  task automatic test_fill();
    int accepted = 0;
    int first_block = -1;
    r_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      w_data  = 16'(100 + i);
      w_valid = 1'b1;
      if (w_ready) accepted++;
      else if (first_block < 0) first_block = i;
      step();
    end
    w_valid = 1'b0;
    n_checks++;
    if (accepted !== 20) $display("[TB] FAIL fill_accepted: got %0d expected 20", accepted); else n_pass++;
    n_checks++;
    if (first_block !== 20) $display("[TB] FAIL fill_first_block: got %0d expected 20", first_block); else n_pass++;
    n_checks++;
    if (w_ready !== 1'b0) $display("[TB] FAIL fill_w_ready: got %b expected 0", w_ready); else n_pass++;
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== 16'd100)
      $display("[TB] FAIL fill_head: got valid=%b data=%0d expected valid=1 data=100", r_valid, r_data);
    else n_pass++;
`ifdef BRAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 6'd20) $display("[TB] FAIL fill_count: got %0d expected 20", count); else n_pass++;
`endif
  endtask

  // Runs with the FIFO left full (100..119) by test_fill.
  task automatic test_full_pop();
    logic [DBITS-1:0] exp_q[$];
    int got = 0;
    for (int i = 1; i < 20; i++) exp_q.push_back(16'(100 + i));
    exp_q.push_back(16'd200);

    w_data  = 16'd200;
    w_valid = 1'b1;
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    n_checks++;
    if (w_ready !== 1'b0) $display("[TB] FAIL fullpop_pop_edge: got w_ready=%b expected 0", w_ready); else n_pass++;
    step();
    n_checks++;
    if (w_ready !== 1'b1) $display("[TB] FAIL fullpop_reenable: got w_ready=%b expected 1", w_ready); else n_pass++;
    step();
    w_valid = 1'b0;
    n_checks++;
    if (w_ready !== 1'b0) $display("[TB] FAIL fullpop_refull: got w_ready=%b expected 0", w_ready); else n_pass++;
`ifdef BRAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 6'd20) $display("[TB] FAIL fullpop_count: got %0d expected 20", count); else n_pass++;
`endif
    r_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      if (r_valid) begin
        n_checks++;
        if (r_data !== exp_q[got]) $display("[TB] FAIL fullpop_drain[%0d]: got %0d expected %0d", got, r_data, exp_q[got]);
        else n_pass++;
        got++;
      end
      step();
    end
    r_ready = 1'b0;
    repeat (4) step();
    n_checks++;
    if (got !== 20) $display("[TB] FAIL fullpop_drain_count: got %0d expected 20", got); else n_pass++;
    n_checks++;
    if (r_valid !== 1'b0) $display("[TB] FAIL fullpop_empty: got %b expected 0", r_valid); else n_pass++;
`ifdef BRAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 6'd0) $display("[TB] FAIL fullpop_empty_count: got %0d expected 0", count); else n_pass++;
`endif
  endtask

  task automatic test_streaming();
    int wr_n = 0, rd_n = 0, gaps = 0, first_acc = -1, first_val = -1;
    r_ready = 1'b1;
    for (int cyc = 0; cyc < 1200 && rd_n < 1000; cyc++) begin
      w_valid = (wr_n < 1000);
      w_data  = 16'(wr_n);
      if (r_valid) begin
        if (first_val < 0) first_val = cyc;
        n_checks++;
        if (r_data !== 16'(rd_n)) $display("[TB] FAIL stream_data[%0d]: got %0d expected %0d", rd_n, r_data, rd_n);
        else n_pass++;
        rd_n++;
      end else if (first_val >= 0) begin
        gaps++;
      end
      if (w_valid && w_ready) begin
        if (first_acc < 0) first_acc = cyc;
        wr_n++;
      end
      step();
    end
    w_valid = 1'b0;
    r_ready = 1'b0;
    n_checks++;
    if (rd_n !== 1000) $display("[TB] FAIL stream_total: got %0d expected 1000", rd_n); else n_pass++;
    n_checks++;
    if (gaps !== 0) $display("[TB] FAIL stream_gaps: got %0d expected 0", gaps); else n_pass++;
    // Iteration cyc samples the state after edge cyc-1; the accept happens on edge first_acc.
    n_checks++;
    if (first_val - 1 - first_acc !== 3)
      $display("[TB] FAIL stream_latency: got %0d edges expected 3", first_val - 1 - first_acc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int wr_n = 0, rd_n = 0, held = 0;
    for (int cyc = 0; cyc < 3000 && rd_n < 100; cyc++) begin
      w_valid = (wr_n < 100);
      w_data  = 16'(16'h4000 + wr_n);
      r_ready = 1'($urandom_range(0, 1));
      if (r_valid && r_ready) begin
        n_checks++;
        if (r_data !== 16'(16'h4000 + rd_n))
          $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", rd_n, r_data, 16'(16'h4000 + rd_n));
        else n_pass++;
        rd_n++;
        held--;
      end
      if (w_valid && w_ready) begin
        wr_n++;
        held++;
      end
      step();
`ifdef BRAM_FIFO_COUNT_EN
      n_checks++;
      if (count !== 6'(held)) $display("[TB] FAIL wrap_count: got %0d expected %0d", count, held); else n_pass++;
`endif
    end
    w_valid = 1'b0;
    r_ready = 1'b0;
    n_checks++;
    if (rd_n !== 100) $display("[TB] FAIL wrap_total: got %0d expected 100", rd_n); else n_pass++;
  endtask

  task automatic test_reset_mid();
    r_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w_data  = 16'(16'h0700 + i);
      w_valid = 1'b1;
      step();
    end
    w_valid = 1'b0;
    repeat (4) step();
`ifdef BRAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 6'd10) $display("[TB] FAIL midreset_pre_count: got %0d expected 10", count); else n_pass++;
`endif
    n_checks++;
    if (r_valid !== 1'b1) $display("[TB] FAIL midreset_pre_valid: got %b expected 1", r_valid); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (r_valid !== 1'b0) $display("[TB] FAIL midreset_valid: got %b expected 0", r_valid); else n_pass++;
    n_checks++;
    if (w_ready !== 1'b0) $display("[TB] FAIL midreset_w_ready: got %b expected 0", w_ready); else n_pass++;
`ifdef BRAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 6'd0) $display("[TB] FAIL midreset_count: got %0d expected 0", count); else n_pass++;
`endif
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (r_valid !== 1'b0) $display("[TB] FAIL midreset_spurious[%0d]: got %b expected 0", k, r_valid); else n_pass++;
    end
    w_data  = 16'h1234;
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== 16'h1234)
      $display("[TB] FAIL midreset_first: got valid=%b data=%h expected valid=1 data=1234", r_valid, r_data);
    else n_pass++;
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    repeat (3) step();
    n_checks++;
    if (r_valid !== 1'b0) $display("[TB] FAIL midreset_only_word: got %b expected 0", r_valid); else n_pass++;
  endtask

  initial begin
    $display("[TB] starting bram_fifo_ctrl bench");
    test_reset();
    test_single_word();
    test_fill();
    test_full_pop();
    test_streaming();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

Synchronous FIFO controller that sequences a `block_ram` instance, a simple dual-port RAM with 2-cycle registered read latency, into a valid/ready stream FIFO. A 4-entry prefetch queue absorbs the RAM read latency so the read side sustains one word per clock. It sits between the PCIe-side packet logic and user FIFO ports in hififo, replacing ad-hoc pointer logic around raw RAM instances.

## Interface
- `ABITS`, 9, RAM address width; RAM depth is 2**ABITS words
- `DBITS`, 64, data width
- `clock`  in  1  sole clock; all logic on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `w_data`  in  DBITS  write data
- `w_valid`  in  1  write request; accepted when `w_valid & w_ready`
- `w_ready`  out  1  RAM not full
- `r_data`  out  DBITS  head-of-FIFO data
- `r_valid`  out  1  prefetch queue non-empty
- `r_ready`  in  1  consumer accepts; pop when `r_valid & r_ready`
- `count`  out  ABITS+2  total words held (present only with `BRAM_FIFO_COUNT_EN`)

## Operation
- Pointers `wptr`, `rptr`: ABITS+1 bits each; RAM address is the low ABITS bits; wrap is natural modulo 2**(ABITS+1).
- RAM empty: `wptr == rptr`. RAM full: `wptr - rptr == 2**ABITS`.
- Write: on accept, RAM written at `wptr[ABITS-1:0]`; `wptr` increments.
- Read issue: when RAM not empty and `q_count + v1 + v2 < 4`, drive `rptr` as RAM read address and increment `rptr`. `v1`/`v2` form a 2-stage in-flight shift register mirroring RAM latency.
- Issue uses registered state only; no combinational path from `r_ready` to the RAM.
- When `v2` is high, RAM `r_data` is written into the prefetch queue on that edge.
- Prefetch queue: 4-entry register FIFO; `r_data` is the head entry, `r_valid = q_count != 0`. Push and pop in the same cycle keep `q_count` unchanged.
- Total capacity: 2**ABITS + 4 words.
- Writes with `w_valid` high while `w_ready` is low are ignored. The producer holds data until it is accepted.
- `r_data` is held stable while `r_valid & !r_ready`.

## Timing
- Reset: `wptr = rptr = 0`, `v1 = v2 = 0`, `q_count = 0`, `r_valid = 0`, `count = 0`. `w_ready = 0` while `reset` is high and `1` the first cycle after. RAM contents are not cleared.
- Reset mid-operation: all queued and in-flight words are discarded immediately. No spurious `r_valid` after release.
- Write-to-read latency into an empty FIFO: write accepted at edge 0, read issued cycle 1, `v2` cycle 2, `r_valid` high cycle 3.
- Throughput: with `r_ready` held high and the writer streaming, one word per clock in steady state.
- Full: `w_ready` falls the cycle after the write that fills the RAM. A read issue in the same cycle does not re-enable writes until the next cycle.
- Empty: `r_valid` falls the cycle after the final pop.
- Write and issue to the same address in one cycle cannot occur, because issue requires not-empty from registered pointers.

## Configuration
- `BRAM_FIFO_COUNT_EN` defined: `count = (wptr - rptr) + v1 + v2 + q_count`, registered, ABITS+2 bits, max 2**ABITS + 4.
- Not defined: the `count` port and its adder logic are absent. Flow control behaviour is identical.

## Structure
- Shared package `hififo_pkg` holds:
  - prefetch depth constant `BRAM_FIFO_QDEPTH = 4`
  - RAM read latency constant `BRAM_RD_LATENCY = 2`
  - pointer width function `ptr_bits(ABITS) = ABITS+1`
- Sub-modules:
  - Instantiates `block_ram` (ABITS, DBITS passed through).
  - One new sub-module, `prefetch_queue`: the 4-entry register FIFO with push/pop/count.

## Test plan
All scenarios run at ABITS=4, DBITS=16: RAM 16 words, capacity 20.
- Single word: write 0xA5A5 at cycle 0 with `r_ready = 0` -> `r_valid` rises at cycle 3 with `r_data = 0xA5A5`, held until `r_ready`.
- Fill: 25 writes offered with `r_ready = 0` -> exactly 20 accepted; `w_ready` low after the 20th accept; `count = 20` (macro on).
- Streaming: continuous writes of 0..999 with `r_ready = 1` -> output 0..999 in order, one per cycle after the initial 3-cycle latency, no gaps.
- Wrap: 100 words with `r_ready` randomly toggled 50% -> data in order across multiple pointer wraps; `count` always equals writes minus pops.
- Reset mid-stream: assert `reset` with 10 words held -> `r_valid = 0` and `count = 0` at once; after release, a new write of 0x1234 reads back as the first word.
- Full plus simultaneous pop: at 20 held, pop one while `w_valid` is high -> write is not accepted that cycle; it is accepted once `w_ready` rises the next cycle after the pop-triggered read issue.
